// File: rtl/bip_pkg.sv
// Shared opcodes, accumulator-source encodings, FSM states and default widths
// for the BIP instruction-sequencing control unit.
package bip_pkg;

  localparam int NBITS_O_DEF = 11;
  localparam int NBITS_E_DEF = 5;
  localparam int NBITS_D_DEF = 16;

  localparam logic [4:0] OP_HLT  = 5'b00000;
  localparam logic [4:0] OP_STO  = 5'b00001;
  localparam logic [4:0] OP_LD   = 5'b00010;
  localparam logic [4:0] OP_LDI  = 5'b00011;
  localparam logic [4:0] OP_ADD  = 5'b00100;
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_SUB  = 5'b00110;
  localparam logic [4:0] OP_SUBI = 5'b00111;

  localparam logic [1:0] SELA_MEM = 2'b00;
  localparam logic [1:0] SELA_IMM = 2'b01;
  localparam logic [1:0] SELA_ALU = 2'b10;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_WB     = 3'd3,
    ST_HALT   = 3'd4
  } state_t;

endpackage

// File: rtl/bip_pc.sv
// Program counter: async reset, synchronous load, increment with silent
// modulo-2^NBITS_O wrap.
module bip_pc #(
  parameter int NBITS_O = 11
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_Inc,
  input  logic               i_Load,
  input  logic [NBITS_O-1:0] i_LoadValue,
  output logic [NBITS_O-1:0] o_Pc
);

  localparam logic [NBITS_O-1:0] PC_ONE = {{(NBITS_O-1){1'b0}}, 1'b1};

  logic [NBITS_O-1:0] pcReg;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      pcReg <= '0;
    end else if (i_Load) begin
      pcReg <= i_LoadValue;
    end else if (i_Inc) begin
      pcReg <= pcReg + PC_ONE;
    end
  end

  assign o_Pc = pcReg;

endmodule

// File: rtl/bip_control.sv
// BIP control unit: multi-cycle Moore FSM sequencing fetch/decode/exec/wb.
// Optional single-step gating of FETCH with macro BIP_CTRL_STEP_EN (adds i_Step).
import bip_pkg::*;

module bip_control #(
  parameter int NBITS_O = NBITS_O_DEF,
  parameter int NBITS_E = NBITS_E_DEF,
  parameter int NBITS_D = NBITS_D_DEF
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic [NBITS_D-1:0] i_Instruction,
  output logic [NBITS_O-1:0] o_PcAddr,
  output logic [NBITS_O-1:0] o_Operand,
  output logic [1:0]         o_SelA,
  output logic               o_SelB,
  output logic               o_WrAcc,
  output logic               o_Op,
  output logic               o_RdRam,
  output logic               o_WrRam,
  output logic               o_Halt
`ifdef BIP_CTRL_STEP_EN
  ,
  input  logic               i_Step
`endif
);

  state_t             state;
  state_t             nextState;
  logic [NBITS_D-1:0] ir;
  logic [NBITS_E-1:0] opcode;
  logic [NBITS_O-1:0] pc;
  logic               pcInc;

  assign opcode = ir[NBITS_D-1 -: NBITS_E];

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state <= ST_FETCH;
    end else begin
      state <= nextState;
    end
  end

  // Memory data for the fetched address is valid during DECODE
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      ir <= '0;
    end else if (state == ST_DECODE) begin
      ir <= i_Instruction;
    end
  end

  // Every entry into FETCH from another state advances the PC
  assign pcInc = (nextState == ST_FETCH) && (state != ST_FETCH);

  bip_pc #(.NBITS_O(NBITS_O)) uPc (
    .i_clock     (i_clock),
    .i_reset     (i_reset),
    .i_Inc       (pcInc),
    .i_Load      (1'b0),
    .i_LoadValue ('0),
    .o_Pc        (pc)
  );

  always_comb begin
    nextState = state;
    o_SelA    = SELA_MEM;
    o_SelB    = 1'b0;
    o_WrAcc   = 1'b0;
    o_Op      = 1'b0;
    o_RdRam   = 1'b0;
    o_WrRam   = 1'b0;
    o_Halt    = 1'b0;
    case (state)
      ST_FETCH: begin
`ifdef BIP_CTRL_STEP_EN
        if (i_Step) nextState = ST_DECODE;
`else
        nextState = ST_DECODE;
`endif
      end
      ST_DECODE: nextState = ST_EXEC;
      ST_EXEC: begin
        nextState = ST_FETCH;
        case (opcode)
          OP_HLT: nextState = ST_HALT;
          OP_STO: o_WrRam = 1'b1;
          OP_LD, OP_ADD, OP_SUB: begin
            o_RdRam   = 1'b1;
            nextState = ST_WB;
          end
          OP_LDI: begin
            o_SelA  = SELA_IMM;
            o_WrAcc = 1'b1;
          end
          OP_ADDI, OP_SUBI: begin
            o_SelA  = SELA_ALU;
            o_SelB  = 1'b1;
            o_Op    = (opcode == OP_SUBI);
            o_WrAcc = 1'b1;
          end
          default: ;
        endcase
      end
      // Only LD/ADD/SUB reach WB: memory data is now on the bus
      ST_WB: begin
        nextState = ST_FETCH;
        o_WrAcc   = 1'b1;
        if (opcode != OP_LD) begin
          o_SelA = SELA_ALU;
          o_Op   = (opcode == OP_SUB);
        end
      end
      ST_HALT: o_Halt = 1'b1;
      default: nextState = ST_FETCH;
    endcase
  end

  assign o_PcAddr  = pc;
  assign o_Operand = ir[NBITS_O-1:0];

endmodule

// File: tb/tb_bip_control.sv
// Self-checking bench for bip_control: a cycle-level reference of each program
// fills an expectation queue that is popped and compared every cycle.
module tb_bip_control;

  typedef struct packed {
    logic        chkPc;
    logic [10:0] pc;
    logic [10:0] opnd;
    logic [1:0]  selA;
    logic        selB;
    logic        wrAcc;
    logic        op;
    logic        rdRam;
    logic        wrRam;
    logic        halt;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [15:0] instr;
  logic [10:0] pcAddr;
  logic [10:0] operand;
  logic [1:0]  selA;
  logic        selB;
  logic        wrAcc;
  logic        op;
  logic        rdRam;
  logic        wrRam;
  logic        halt;
`ifdef BIP_CTRL_STEP_EN
  logic        step;
`endif

  logic [15:0] mem [0:2047];
  exp_t        sbQ[$];
  int          total = 0;
  int          bad = 0;

  bip_control dut (
    .i_clock       (clk),
    .i_reset       (rst),
    .i_Instruction (instr),
    .o_PcAddr      (pcAddr),
    .o_Operand     (operand),
    .o_SelA        (selA),
    .o_SelB        (selB),
    .o_WrAcc       (wrAcc),
    .o_Op          (op),
    .o_RdRam       (rdRam),
    .o_WrRam       (wrRam),
    .o_Halt        (halt)
`ifdef BIP_CTRL_STEP_EN
    ,
    .i_Step        (step)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous program memory: data follows the address by one cycle
  always @(posedge clk) instr <= mem[pcAddr];

  function automatic exp_t sample();
    exp_t s;
    s       = '0;
    s.pc    = pcAddr;
    s.opnd  = operand;
    s.selA  = selA;
    s.selB  = selB;
    s.wrAcc = wrAcc;
    s.op    = op;
    s.rdRam = rdRam;
    s.wrRam = wrRam;
    s.halt  = halt;
    return s;
  endfunction

  function automatic void clearMem(logic [15:0] fill);
    for (int i = 0; i < 2048; i++) mem[i] = fill;
  endfunction

  // Instruction-level reference expanded into per-cycle expected outputs
  function automatic void buildExpect(int n);
    logic [10:0] pc = '0;
    logic [15:0] ir = '0;
    logic [4:0]  opc;
    bit          halted = 0;
    exp_t        e;
    sbQ.delete();
    while (sbQ.size() < n) begin
      if (halted) begin
        e = '0; e.chkPc = 1; e.pc = pc; e.opnd = ir[10:0]; e.halt = 1;
        sbQ.push_back(e);
      end else begin
        e = '0; e.chkPc = 1; e.pc = pc; e.opnd = ir[10:0];
        sbQ.push_back(e);
        e.chkPc = 0;
        sbQ.push_back(e);
        ir = mem[pc];
        opc = ir[15:11];
        e = '0; e.pc = pc; e.opnd = ir[10:0];
        case (opc)
          5'd0: begin sbQ.push_back(e); halted = 1; end
          5'd1: begin e.wrRam = 1; sbQ.push_back(e); end
          5'd2, 5'd4, 5'd6: begin
            e.rdRam = 1; sbQ.push_back(e);
            e.rdRam = 0; e.wrAcc = 1;
            e.selA = (opc == 5'd2) ? 2'b00 : 2'b10;
            e.op = (opc == 5'd6);
            sbQ.push_back(e);
          end
          5'd3: begin e.selA = 2'b01; e.wrAcc = 1; sbQ.push_back(e); end
          5'd5, 5'd7: begin
            e.selA = 2'b10; e.selB = 1; e.op = (opc == 5'd7); e.wrAcc = 1;
            sbQ.push_back(e);
          end
          default: sbQ.push_back(e);
        endcase
        if (!halted) pc = pc + 11'd1;
      end
    end
  endfunction

  // Reset the DUT and release it at a falling edge with FETCH at PC 0 showing
  task automatic startRun(int n);
    buildExpect(n);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    exp_t act;
    rst = 1'b1;
    @(negedge clk);
    act = sample();
    total++;
    if (act !== exp_t'(0)) begin
      bad++;
      $display("FAIL reset_outputs got=%h exp=%h", act, exp_t'(0));
    end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (pcAddr !== 11'd0 || halt !== 1'b0) begin
      bad++;
      $display("FAIL reset_release_pc got=%h exp=0", pcAddr);
    end
  endtask

  task automatic test_ldi();
    exp_t act, e;
    clearMem(16'h0000);
    mem[0] = 16'h187B;
    startRun(10);
    for (int k = 0; k < 10; k++) begin
      act = sample();
      e = sbQ.pop_front();
      act.chkPc = e.chkPc;
      if (!e.chkPc) act.pc = e.pc;
      total++;
      if (act !== e) begin
        bad++;
        $display("FAIL ldi cyc%0d got=%h exp=%h", k, act, e);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_add();
    exp_t act, e;
    clearMem(16'h0000);
    mem[0] = 16'h2005;
    startRun(10);
    for (int k = 0; k < 10; k++) begin
      act = sample();
      e = sbQ.pop_front();
      act.chkPc = e.chkPc;
      if (!e.chkPc) act.pc = e.pc;
      total++;
      if (act !== e) begin
        bad++;
        $display("FAIL add cyc%0d got=%h exp=%h", k, act, e);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_subi_sto_hlt();
    exp_t act, e;
    clearMem(16'h0000);
    mem[0] = 16'h3803;
    mem[1] = 16'h0802;
    mem[2] = 16'h0000;
    startRun(34);
    for (int k = 0; k < 34; k++) begin
      act = sample();
      e = sbQ.pop_front();
      act.chkPc = e.chkPc;
      if (!e.chkPc) act.pc = e.pc;
      total++;
      if (act !== e) begin
        bad++;
        $display("FAIL subi_sto_hlt cyc%0d got=%h exp=%h", k, act, e);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_mixed();
    exp_t act, e;
    clearMem(16'h0000);
    mem[0] = 16'h101A;
    mem[1] = 16'h3007;
    mem[2] = 16'h2809;
    mem[3] = 16'h4005;
    mem[4] = 16'h1812;
    mem[5] = 16'h7FFF;
    mem[6] = 16'h2133;
    startRun(32);
    for (int k = 0; k < 32; k++) begin
      act = sample();
      e = sbQ.pop_front();
      act.chkPc = e.chkPc;
      if (!e.chkPc) act.pc = e.pc;
      total++;
      if (act !== e) begin
        bad++;
        $display("FAIL mixed cyc%0d got=%h exp=%h", k, act, e);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_nop_wrap();
    exp_t act, e;
    for (int i = 0; i < 2048; i++) mem[i] = 16'hF800 | 16'(i);
    startRun(2049 * 3 + 4);
    for (int k = 0; k < 2049 * 3 + 4; k++) begin
      act = sample();
      e = sbQ.pop_front();
      act.chkPc = e.chkPc;
      if (!e.chkPc) act.pc = e.pc;
      total++;
      if (act !== e) begin
        bad++;
        $display("FAIL nop_wrap cyc%0d got=%h exp=%h", k, act, e);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_async_reset();
    clearMem(16'h0000);
    mem[0] = 16'h187B;
    startRun(1);
    @(posedge clk);
    @(posedge clk);
    #3;
    total++;
    if (wrAcc !== 1'b1 || selA !== 2'b01) begin
      bad++;
      $display("FAIL async_pre_exec got=%b/%b exp=1/01", wrAcc, selA);
    end
    rst = 1'b1;
    #1;
    total++;
    if (sample() !== exp_t'(0)) begin
      bad++;
      $display("FAIL async_abort got=%h exp=%h", sample(), exp_t'(0));
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++;
    if (pcAddr !== 11'd0 || wrAcc !== 1'b0) begin
      bad++;
      $display("FAIL async_release got=%h exp=0", pcAddr);
    end
    @(posedge clk);
    @(posedge clk);
    #3;
    total++;
    if (wrAcc !== 1'b1 || operand !== 11'h07B || pcAddr !== 11'd0) begin
      bad++;
      $display("FAIL async_restart got=%b/%h exp=1/07b", wrAcc, operand);
    end
  endtask

`ifdef BIP_CTRL_STEP_EN
  task automatic test_step();
    exp_t act, e;
    clearMem(16'h0000);
    mem[0] = 16'h187B;
    step = 1'b0;
    sbQ.delete();
    for (int k = 0; k < 10; k++) begin
      e = '0; e.chkPc = 1;
      sbQ.push_back(e);
    end
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      act = sample();
      e = sbQ.pop_front();
      act.chkPc = e.chkPc;
      total++;
      if (act !== e) begin
        bad++;
        $display("FAIL step_hold cyc%0d got=%h exp=%h", k, act, e);
      end
      @(negedge clk);
    end
    e = '0;
    sbQ.push_back(e);
    e.opnd = 11'h07B; e.selA = 2'b01; e.wrAcc = 1;
    sbQ.push_back(e);
    for (int k = 0; k < 6; k++) begin
      e = '0; e.chkPc = 1; e.pc = 11'd1; e.opnd = 11'h07B;
      sbQ.push_back(e);
    end
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    for (int k = 0; k < 8; k++) begin
      act = sample();
      e = sbQ.pop_front();
      act.chkPc = e.chkPc;
      if (!e.chkPc) act.pc = e.pc;
      total++;
      if (act !== e) begin
        bad++;
        $display("FAIL step_one cyc%0d got=%h exp=%h", k, act, e);
      end
      @(negedge clk);
    end
    step = 1'b1;
  endtask
`endif

  initial begin
    rst = 1'b1;
    clearMem(16'h0000);
`ifdef BIP_CTRL_STEP_EN
    step = 1'b1;
`endif
    @(negedge clk);
    test_reset();
    test_ldi();
    test_add();
    test_subi_sto_hlt();
    test_mixed();
    test_async_reset();
    test_nop_wrap();
`ifdef BIP_CTRL_STEP_EN
    test_step();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
